// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader_if
//  Description : Bundle of the beat-input and core-facing signals of the
//                instruction loader.
//                  slave  : the loader itself (consumes beats, drives the core)
//                  master : whatever sits around it (beat source + core)
//                Ports carried:
//                  FLUSH        -> loader   synchronous clear
//                  DIN/DIN_STB  -> loader   instruction beat + strobe
//                  DIN_BUSY     <- loader   beats cannot be accepted
//                  OVERFLOW     <- loader   sticky dropped-beat flag
//                  INSTRUCTION  <- loader   FIFO head (0 when empty)
//                  INSTR_VALID  <- loader   FIFO non-empty
//                  INSTR_READY  -> loader   core takes the head this cycle
//                  write_en     <- loader   issue strobe
//                  PC           <- loader   issued-instruction counter
//                  FIFO_COUNT   <- loader   entries held
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_loader_if #(
    parameter int BEAT_W  = 3,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 3
) ();
    logic               FLUSH;
    logic [BEAT_W-1:0]  DIN;
    logic               DIN_STB;
    logic               DIN_BUSY;
    logic               OVERFLOW;
    logic [INSTR_W-1:0] INSTRUCTION;
    logic               INSTR_VALID;
    logic               INSTR_READY;
    logic               write_en;
    logic [INSTR_W-1:0] PC;
    logic [CNT_W-1:0]   FIFO_COUNT;

    modport slave (
        input  FLUSH,
        input  DIN,
        input  DIN_STB,
        input  INSTR_READY,
        output DIN_BUSY,
        output OVERFLOW,
        output INSTRUCTION,
        output INSTR_VALID,
        output write_en,
        output PC,
        output FIFO_COUNT
    );

    modport master (
        output FLUSH,
        output DIN,
        output DIN_STB,
        output INSTR_READY,
        input  DIN_BUSY,
        input  OVERFLOW,
        input  INSTRUCTION,
        input  INSTR_VALID,
        input  write_en,
        input  PC,
        input  FIFO_COUNT
    );
endinterface
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader
//  Description : Front end of the cpu core. Assembles INSTR_W-bit instructions
//                from three BEAT_W-bit beats (first beat = most significant),
//                queues them in a DEPTH-entry first-word-fall-through FIFO and
//                hands the head to the core with a valid/ready handshake.
//                PC counts instructions issued to the core.
//  Ports       : CLK    - clock, rising edge
//                RESET  - asynchronous, active-high reset
//                bus    - instr_loader_if.slave (beat input, core handshake,
//                         status: DIN_BUSY, OVERFLOW, PC, FIFO_COUNT)
//  Revision    : 1.0  initial release
// ============================================================================
module instr_loader #(
    parameter int DEPTH   = 4,
    parameter int BEAT_W  = 3,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 3
) (
    input  wire logic       CLK,
    input  wire logic       RESET,
    instr_loader_if.slave   bus
);

    localparam int               PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               HOLD_W = INSTR_W - BEAT_W;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    // ------------------------------------------------------------------------
    // Assembler state: which beat of the current word is expected next.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } asm_state_t;

    asm_state_t         r_state;
    asm_state_t         w_state_next;

    // Upper two beats of the word in progress; the third beat is taken
    // straight from DIN when the word is pushed.
    logic [HOLD_W-1:0]  r_hold;

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [INSTR_W-1:0] r_pc;
    logic               r_overflow;

    logic               w_busy;
    logic               w_valid;
    logic               w_accept;
    logic               w_push;
    logic               w_fire;
    logic [INSTR_W-1:0] w_word;

    // ------------------------------------------------------------------------
    // Handshake decode. Busy looks only at the registered count, so a pop in
    // the current cycle does not open the input for a beat in the same cycle.
    // ------------------------------------------------------------------------
    assign w_busy   = (r_count == C_FULL);
    assign w_valid  = (r_count != '0);
    assign w_accept = bus.DIN_STB & ~w_busy;
    assign w_fire   = w_valid & bus.INSTR_READY & ~bus.FLUSH;
    assign w_word   = {r_hold, bus.DIN};

    // ------------------------------------------------------------------------
    // Assembler FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= B0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Assembler FSM: next state and push decode. FLUSH abandons any partial
    // word and blocks the push of a word completing in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        if (bus.FLUSH) begin
            w_state_next = B0;
        end else if (w_accept) begin
            case (r_state)
                B0:      w_state_next = B1;
                B1:      w_state_next = B2;
                B2: begin
                    w_state_next = B0;
                    w_push       = 1'b1;
                end
                default: w_state_next = B0;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Beat capture into the hold register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hold <= '0;
        end else if (bus.FLUSH) begin
            r_hold <= '0;
        end else if (w_accept) begin
            case (r_state)
                B0:      r_hold[HOLD_W-1 -: BEAT_W] <= bus.DIN;
                B1:      r_hold[BEAT_W-1:0]         <= bus.DIN;
                default: r_hold                     <= r_hold;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage. Entries need no reset: they are only visible while the
    // count says they hold a pushed word.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy. DEPTH is a power of two, so the natural
    // PTR_W-bit wrap gives modulo-DEPTH addressing.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_fire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Issue counter and sticky overflow. Neither is touched by FLUSH.
    // A strobe against a full FIFO is a dropped beat.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pc       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_fire) begin
                r_pc <= r_pc + INSTR_W'(1);
            end
            if (bus.DIN_STB && w_busy) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.DIN_BUSY    = w_busy;
    assign bus.OVERFLOW    = r_overflow;
    assign bus.INSTR_VALID = w_valid;
    assign bus.INSTRUCTION = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.write_en    = w_fire;
    assign bus.PC          = r_pc;
    assign bus.FIFO_COUNT  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_loader
//  Description : Self-checking bench for instr_loader: a table of hand-derived
//                vectors, directed corner-case sequences, and random stimulus
//                compared against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_loader;

    localparam int DEPTH   = 4;
    localparam int BEAT_W  = 3;
    localparam int INSTR_W = 9;
    localparam int CNT_W   = 3;

    logic clk;
    logic rst;

    instr_loader_if #(.BEAT_W(BEAT_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

    instr_loader #(
        .DEPTH   (DEPTH),
        .BEAT_W  (BEAT_W),
        .INSTR_W (INSTR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d (0x%0h) want=%0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: the FIFO is a queue of whole words, the assembler is a
    // running value plus a beat tally.
    // ------------------------------------------------------------------------
    int m_q[$];
    int m_part;
    int m_nb;
    int m_pc;
    int m_ovf;

    // values sampled from the DUT in the most recent cycle()
    int s_we;
    int s_instr;

    function automatic void model_reset();
        m_q.delete();
        m_part = 0;
        m_nb   = 0;
        m_pc   = 0;
        m_ovf  = 0;
    endfunction

    // One clock cycle: drive inputs, compare everything with the model just
    // before the edge, advance the model, and step past the edge.
    task automatic cycle(input bit f, input bit s, input int d, input bit r);
        int e_valid, e_instr, e_cnt, e_busy, e_we;
        bus.FLUSH       = f;
        bus.DIN_STB     = s;
        bus.DIN         = 3'(d);
        bus.INSTR_READY = r;
        #3;
        e_cnt   = m_q.size();
        e_valid = (e_cnt != 0);
        e_instr = e_valid ? m_q[0] : 0;
        e_busy  = (e_cnt == DEPTH);
        e_we    = (e_valid && r && !f);
        s_we    = int'(bus.write_en);
        s_instr = int'(bus.INSTRUCTION);
        chk("valid",    int'(bus.INSTR_VALID), e_valid);
        chk("instr",    s_instr,               e_instr);
        chk("count",    int'(bus.FIFO_COUNT),  e_cnt);
        chk("busy",     int'(bus.DIN_BUSY),    e_busy);
        chk("write_en", s_we,                  e_we);
        chk("pc",       int'(bus.PC),          m_pc);
        chk("overflow", int'(bus.OVERFLOW),    m_ovf);
        if (f) begin
            m_q.delete();
            m_part = 0;
            m_nb   = 0;
        end else begin
            if (e_we != 0) begin
                void'(m_q.pop_front());
                m_pc = (m_pc + 1) % 512;
            end
            if (s) begin
                if (e_busy != 0) begin
                    m_ovf = 1;
                end else begin
                    m_part = m_part * 8 + (d & 7);
                    m_nb++;
                    if (m_nb == 3) begin
                        m_q.push_back(m_part);
                        m_part = 0;
                        m_nb   = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int w, input bit r);
        cycle(1'b0, 1'b1, (w >> 6) & 7, r);
        cycle(1'b0, 1'b1, (w >> 3) & 7, r);
        cycle(1'b0, 1'b1, w & 7, r);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.FLUSH       = 1'b0;
        bus.DIN_STB     = 1'b0;
        bus.DIN         = '0;
        bus.INSTR_READY = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------------
    // Vector table: inputs plus hand-derived pre-edge outputs
    // ------------------------------------------------------------------------
    typedef struct {
        logic       f;
        logic       s;
        logic [2:0] d;
        logic       r;
        logic       v;
        logic [8:0] ins;
        logic [2:0] cnt;
        logic       we;
        logic       busy;
        logic [8:0] pc;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int nfire;
        int wexp[4];
        int rp;

        // first word 0x153 from reset, then issue it
        tbl[0]  = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 1'b0, 9'd0};
        tbl[1]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 1'b0, 9'd0};
        tbl[2]  = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 1'b0, 9'd0};
        tbl[3]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 9'h153, 3'd1, 1'b0, 1'b0, 9'd0};
        tbl[4]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 9'h153, 3'd1, 1'b1, 1'b0, 9'd0};
        tbl[5]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 1'b0, 9'd1};
        // 0x0AA, 0x155 loaded, then 0x1FF completes while 0x0AA issues
        tbl[6]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 1'b0, 9'd1};
        tbl[7]  = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 1'b0, 9'd1};
        tbl[8]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 1'b0, 9'd1};
        tbl[9]  = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 9'h0AA, 3'd1, 1'b0, 1'b0, 9'd1};
        tbl[10] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 9'h0AA, 3'd1, 1'b0, 1'b0, 9'd1};
        tbl[11] = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 9'h0AA, 3'd1, 1'b0, 1'b0, 9'd1};
        tbl[12] = '{1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 9'h0AA, 3'd2, 1'b0, 1'b0, 9'd1};
        tbl[13] = '{1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 9'h0AA, 3'd2, 1'b0, 1'b0, 9'd1};
        tbl[14] = '{1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 9'h0AA, 3'd2, 1'b1, 1'b0, 9'd1};
        tbl[15] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 9'h155, 3'd2, 1'b0, 1'b0, 9'd2};
        tbl[16] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 9'h155, 3'd2, 1'b1, 1'b0, 9'd2};
        tbl[17] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 9'h1FF, 3'd1, 1'b1, 1'b0, 9'd3};
        tbl[18] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 1'b0, 9'd4};

        do_reset();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 19; i++) begin
            bus.FLUSH       = tbl[i].f;
            bus.DIN_STB     = tbl[i].s;
            bus.DIN         = tbl[i].d;
            bus.INSTR_READY = tbl[i].r;
            #3;
            chk($sformatf("tbl%0d_valid", i), int'(bus.INSTR_VALID), int'(tbl[i].v));
            chk($sformatf("tbl%0d_instr", i), int'(bus.INSTRUCTION), int'(tbl[i].ins));
            chk($sformatf("tbl%0d_count", i), int'(bus.FIFO_COUNT),  int'(tbl[i].cnt));
            chk($sformatf("tbl%0d_we", i),    int'(bus.write_en),    int'(tbl[i].we));
            chk($sformatf("tbl%0d_busy", i),  int'(bus.DIN_BUSY),    int'(tbl[i].busy));
            chk($sformatf("tbl%0d_pc", i),    int'(bus.PC),          int'(tbl[i].pc));
            chk($sformatf("tbl%0d_ovf", i),   int'(bus.OVERFLOW),    0);
            @(posedge clk);
            #1;
        end

        // ---------------- fill, overflow, drain ----------------
        do_reset();
        wexp[0] = 'h001; wexp[1] = 'h0AA; wexp[2] = 'h155; wexp[3] = 'h1FF;
        for (int i = 0; i < 4; i++) send_word(wexp[i], 1'b0);
        chk("full_count", int'(bus.FIFO_COUNT), 4);
        chk("full_busy",  int'(bus.DIN_BUSY),   1);
        chk("full_ovf0",  int'(bus.OVERFLOW),   0);
        cycle(1'b0, 1'b1, 6, 1'b0);
        chk("drop_ovf",   int'(bus.OVERFLOW),   1);
        chk("drop_count", int'(bus.FIFO_COUNT), 4);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 0, 1'b1);
            chk($sformatf("drain%0d_we", i),    s_we,    1);
            chk($sformatf("drain%0d_instr", i), s_instr, wexp[i]);
        end
        chk("drain_pc",    int'(bus.PC),          4);
        chk("drain_valid", int'(bus.INSTR_VALID), 0);
        chk("drain_instr", int'(bus.INSTRUCTION), 0);
        // the dropped beat must not have advanced the assembler
        send_word('h0C3, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b0);
        chk("after_drop_word", s_instr, 'h0C3);
        chk("ovf_sticky",      int'(bus.OVERFLOW), 1);

        // ---------------- 512-word stream, PC wrap ----------------
        do_reset();
        nfire = 0;
        for (int w = 0; w < 512; w++) begin
            for (int b = 0; b < 3; b++) begin
                cycle(1'b0, 1'b1, (w >> (6 - 3 * b)) & 7, 1'b1);
                if (s_we != 0) begin
                    nfire++;
                    if (nfire == 511) chk("pc_511", int'(bus.PC), 511);
                end
            end
        end
        for (int k = 0; k < 10 && nfire < 512; k++) begin
            cycle(1'b0, 1'b0, 0, 1'b1);
            if (s_we != 0) nfire++;
        end
        chk("stream_fires", nfire, 512);
        chk("pc_wrap",      int'(bus.PC),       0);
        chk("stream_ovf",   int'(bus.OVERFLOW), 0);

        // ---------------- asynchronous reset mid-word ----------------
        do_reset();
        send_word('h153, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b1);
        send_word('h0AA, 1'b0);
        cycle(1'b0, 1'b1, 7, 1'b0);
        cycle(1'b0, 1'b1, 7, 1'b0);
        chk("pre_rst_pc",    int'(bus.PC),         1);
        chk("pre_rst_count", int'(bus.FIFO_COUNT), 1);
        bus.DIN_STB     = 1'b0;
        bus.INSTR_READY = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", int'(bus.INSTR_VALID), 0);
        chk("arst_instr", int'(bus.INSTRUCTION), 0);
        chk("arst_count", int'(bus.FIFO_COUNT),  0);
        chk("arst_pc",    int'(bus.PC),          0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b1, 7, 1'b0);
        cycle(1'b0, 1'b1, 0, 1'b0);
        cycle(1'b0, 1'b1, 1, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b0);
        chk("post_rst_word", s_instr, 'h1C1);

        // ---------------- FLUSH with partial word and full-ish FIFO ----------------
        do_reset();
        for (int i = 0; i < 5; i++) send_word(37 * i + 3, 1'b1);
        cycle(1'b0, 1'b0, 0, 1'b1);
        chk("pre_flush_pc", int'(bus.PC), 5);
        for (int i = 0; i < 3; i++) send_word(100 + i, 1'b0);
        cycle(1'b0, 1'b1, 5, 1'b0);
        chk("pre_flush_count", int'(bus.FIFO_COUNT), 3);
        cycle(1'b1, 1'b0, 0, 1'b1);
        chk("flush_we",    s_we,                 0);
        chk("flush_count", int'(bus.FIFO_COUNT), 0);
        chk("flush_pc",    int'(bus.PC),         5);
        cycle(1'b0, 1'b1, 6, 1'b0);
        cycle(1'b0, 1'b1, 1, 1'b0);
        cycle(1'b0, 1'b1, 4, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b0);
        chk("post_flush_word",  s_instr,              'h18C);
        chk("post_flush_count", int'(bus.FIFO_COUNT), 1);

        // ---------------- random stimulus against the model ----------------
        do_reset();
        rp = 50;
        for (int n = 0; n < 3000; n++) begin
            bit f, s, r;
            if (n % 200 == 0) rp = (rp == 20) ? 85 : 20;
            f = ($urandom_range(0, 31) == 0);
            s = f ? 1'b0 : ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 99) < rp);
            cycle(f, s, int'($urandom_range(0, 7)), r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
